// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one external FP32 multiplier among N_REQ requesters.
// Define FP_MUL_STICKY_FLAGS_EN to accumulate multiplier flags into sticky_exc/ovf/unf.
module fp_mul_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [31:0]        rsp_result,
  output logic               rsp_exception,
  output logic               rsp_overflow,
  output logic               rsp_underflow,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  input  logic [31:0]        mul_result,
  input  logic               mul_exception,
  input  logic               mul_overflow,
  input  logic               mul_underflow,
  output logic               busy,
  input  logic               flag_clr,
  output logic               sticky_exc,
  output logic               sticky_ovf,
  output logic               sticky_unf
);

  // state    | meaning
  // ST_IDLE  | arbitrating; req_ready may assert for the round-robin winner
  // ST_ISSUE | winner's operands on mul_a/mul_b; product captured at next edge
  // ST_RESP  | response held on the bus until the granted requester accepts
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    gnt_idx_q, gnt_idx_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [2:0]       rsp_flags_q, rsp_flags_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic             pick_found;
  logic [IW-1:0]    pick_idx;

  // Search starts one past the last winner so the last winner has lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!pick_found && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && pick_found) begin
      req_ready[pick_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_idx_d    = gnt_idx_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          mul_a_d   = req_a[32*int'(pick_idx) +: 32];
          mul_b_d   = req_b[32*int'(pick_idx) +: 32];
          gnt_idx_d = pick_idx;
          rr_ptr_d  = pick_idx;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rsp_result_d           = mul_result;
        rsp_flags_d            = {mul_exception, mul_overflow, mul_underflow};
        rsp_valid_d            = '0;
        rsp_valid_d[gnt_idx_q] = 1'b1;
        state_d                = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[gnt_idx_q]) begin
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= IW'(N_REQ - 1);
      gnt_idx_q    <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_idx_q    <= gnt_idx_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_exception = rsp_flags_q[2];
  assign rsp_overflow  = rsp_flags_q[1];
  assign rsp_underflow = rsp_flags_q[0];
  assign rsp_valid     = rsp_valid_q;
  assign busy          = (state_q != ST_IDLE);

`ifdef FP_MUL_STICKY_FLAGS_EN
  logic [2:0] sticky_q, sticky_d;

  // Clear is applied before the set so a flag raised on the clear edge survives.
  always_comb begin
    sticky_d = flag_clr ? 3'b000 : sticky_q;
    if (state_q == ST_ISSUE) begin
      sticky_d = sticky_d | {mul_exception, mul_overflow, mul_underflow};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 3'b000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_exc = sticky_q[2];
  assign sticky_ovf = sticky_q[1];
  assign sticky_unf = sticky_q[0];
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign sticky_exc      = 1'b0;
  assign sticky_ovf      = 1'b0;
  assign sticky_unf      = 1'b0;
`endif

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one combinational IEEE-754 single-precision `Multiplication` datapath among N_REQ requesters.
- Arbitration is round-robin, with a valid/ready request handshake per requester.
- Registers the multiplier operands and captures its result and flags (Exception, Overflow, Underflow).
- Returns the captured result to the granted requester on a shared response bus with one-hot valid.

Parameters:
N_REQ, 4, number of requesters (2..8)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester request valid
req_a  input  32*N_REQ  operand A, requester i at bits [32i+31:32i]
req_b  input  32*N_REQ  operand B, same packing
req_ready  output  N_REQ  one-hot grant/accept
rsp_valid  output  N_REQ  one-hot response valid
rsp_ready  input  N_REQ  per-requester response accept
rsp_result  output  32  captured product
rsp_exception  output  1  captured Exception
rsp_overflow  output  1  captured Overflow
rsp_underflow  output  1  captured Underflow
mul_a  output  32  registered operand to multiplier
mul_b  output  32  registered operand to multiplier
mul_result  input  32  multiplier result
mul_exception  input  1  multiplier Exception
mul_overflow  input  1  multiplier Overflow
mul_underflow  input  1  multiplier Underflow
busy  output  1  high whenever state != IDLE
flag_clr  input  1  clears sticky flags (optional feature)
sticky_exc, sticky_ovf, sticky_unf  output  1 each  sticky flags (optional feature)

Behaviour:
- Reset (rst high at posedge, any state):
  - state=IDLE; rr_ptr=N_REQ-1.
  - mul_a=mul_b=0; rsp_result=0; rsp_* flags=0.
  - rsp_valid=0; busy=0; sticky flags=0.
  - Any in-flight op is discarded; no response is ever issued for it.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready is combinational: a one-hot bit for the first requester with req_valid=1, searching from (rr_ptr+1) mod N_REQ upward with wrap.
  - req_ready is all-zero if no request is valid, and in every state other than IDLE.
  - Accept edge T (any req_valid & req_ready): mul_a/mul_b <= winner's operands; gnt_idx <= winner; rr_ptr <= winner; state -> ISSUE.
- ISSUE (edge T+1):
  - rsp_result/flags <= mul_result/mul_*.
  - rsp_valid[gnt_idx] <= 1; state -> RESP.
  - rsp_valid is therefore first visible after edge T+1, a latency of 2 edges from accept.
- RESP:
  - Outputs held stable until rsp_ready[gnt_idx] is sampled high.
  - On that edge: rsp_valid <= 0, state -> IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
  - The next accept is at the earliest on the following edge, so peak throughput is 1 op per 3 cycles.
- mul_a/mul_b hold their last value outside ISSUE; the multiplier output is sampled only in ISSUE.
- Requester rules: req_valid and operands must stay stable until accepted. The block does not check this.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait. Starvation-free, with max wait of N_REQ-1 ops.
- A single requester re-requesting is granted again if no other request is pending.
- A requester may raise req_valid for its next op while its own response is pending; it is eligible in the next IDLE.

Optional Feature:
FP_MUL_STICKY_FLAGS_EN
- Defined:
  - In ISSUE, each sticky_* <= sticky_* | corresponding mul_* flag.
  - flag_clr high clears all three on that edge.
  - If flag_clr and a set happen on the same edge, set wins (the new flag is preserved).
  - Reset clears all three.
- Undefined: sticky_* are constant 0 and flag_clr is ignored. Ports are present in both builds.

Test Plan:
- Single op: requester 0 sends a=40000000, b=40400000 (2.0*3.0), rsp_ready=1 → rsp_valid=0001 two edges after accept; rsp_result=40C00000; all flags 0.
- All four request simultaneously after reset, a=b=3FC00000 (1.5*1.5) → grants in order 0,1,2,3; each rsp_result=40100000; exactly one req_ready/rsp_valid bit high at any time.
- Backpressure: requester 1 op pending, rsp_ready held 0 for 10 cycles, requester 2 requesting → rsp_valid[1] and rsp_result stable; req_ready=0 throughout. Requester 2 is granted the cycle after rsp_ready[1] is sampled high.
- Overflow: a=b=7F000000 → rsp_overflow=1. With FP_MUL_STICKY_FLAGS_EN, sticky_ovf=1 persists after a following 2.0*3.0 op. It clears on a flag_clr pulse.
- Reset mid-op: assert rst for 1 cycle while in ISSUE → next cycle state IDLE, busy=0, rsp_valid=0; no response for the aborted op. A new request from requester 0 completes normally.
- Fairness: requesters 0 and 3 hold req_valid continuously for 8 ops → grants alternate 0,3,0,3,...
